// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU and the multiply/divide unit.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SRL  = 4'd4;
  localparam logic [3:0] ALU_SRA  = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLTU = 4'd10;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers and start/busy handshake.
module md_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC) + 1;

  logic [0:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] prod;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   q_mag;
  logic [WIDTH-1:0]   r_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;

  assign busy = (state == RUN);

  // Signed divide goes through magnitudes so MIN / -1 wraps to MIN with zero remainder.
  always_comb begin
    ext_a = {{WIDTH{(op_q == MD_MULT) & a_q[WIDTH-1]}}, a_q};
    ext_b = {{WIDTH{(op_q == MD_MULT) & b_q[WIDTH-1]}}, b_q};
    prod  = ext_a * ext_b;
    a_neg = (op_q == MD_DIV) & a_q[WIDTH-1];
    b_neg = (op_q == MD_DIV) & b_q[WIDTH-1];
    a_mag = a_neg ? -a_q : a_q;
    b_mag = b_neg ? -b_q : b_q;
    q_mag = '0;
    r_mag = '0;
    if (b_mag != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem  = a_neg ? -r_mag : r_mag;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (md_start) begin
            case (md_op)
              MD_MULT, MD_MULTU: begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= md_op;
                cnt   <= CW'(MUL_CYCLES);
                state <= RUN;
              end
              MD_DIV, MD_DIVU: begin
                a_q   <= A;
                b_q   <= B;
                op_q  <= md_op;
                cnt   <= CW'(DIV_CYCLES);
                state <= RUN;
              end
              MD_MTHI: hi <= A;
              MD_MTLO: lo <= A;
              default: ;
            endcase
          end
        end
        default: begin
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= IDLE;
            if (op_q == MD_MULT || op_q == MD_MULTU) begin
              hi <= prod[2*WIDTH-1:WIDTH];
              lo <= prod[WIDTH-1:0];
            end else if (b_q != '0) begin
              hi <= rem;
              lo <= quot;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// EX-stage ALU: combinational op mux plus the multi-cycle multiply/divide unit.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUOp,
  output logic [WIDTH-1:0] C,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [SHW-1:0] shamt;

  assign shamt = B[SHW-1:0];

  always_comb begin
    C = '0;
    case (ALUOp)
      ALU_ADD:  C = A + B;
      ALU_SUB:  C = A - B;
      ALU_AND:  C = A & B;
      ALU_OR:   C = A | B;
      ALU_SRL:  C = A >> shamt;
      ALU_SRA:  C = WIDTH'($signed(A) >>> shamt);
      ALU_XOR:  C = A ^ B;
      ALU_NOR:  C = ~(A | B);
      ALU_SLL:  C = A << shamt;
      ALU_SLT:  C = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      ALU_SLTU: C = {{(WIDTH-1){1'b0}}, (A < B)};
      default:  C = '0;
    endcase
  end

  md_unit #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_md (
    .clk      (clk),
    .reset    (reset),
    .A        (A),
    .B        (B),
    .md_start (md_start),
    .md_op    (md_op),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu: 32-bit default instance plus a 16-bit, 1-cycle-multiply instance.
module tb_alu_mdu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [3:0]  alu_op = '0;
  logic [31:0] c;
  logic        md_start = 1'b0;
  logic [2:0]  md_op = '0;
  logic        busy;
  logic [31:0] hi, lo;

  logic [15:0] a16 = '0, b16 = '0;
  logic [3:0]  alu_op16 = '0;
  logic [15:0] c16;
  logic        md_start16 = 1'b0;
  logic [2:0]  md_op16 = '0;
  logic        busy16;
  logic [15:0] hi16, lo16;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_mdu #(.WIDTH(32), .MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .A(a), .B(b), .ALUOp(alu_op), .C(c),
    .md_start(md_start), .md_op(md_op), .busy(busy), .hi(hi), .lo(lo)
  );

  alu_mdu #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(10)) dut16 (
    .clk(clk), .reset(reset), .A(a16), .B(b16), .ALUOp(alu_op16), .C(c16),
    .md_start(md_start16), .md_op(md_op16), .busy(busy16), .hi(hi16), .lo(lo16)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op for a cycle, then count busy cycles (bounded); optionally scramble A/B in RUN.
  task automatic run_md(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb,
                        input bit scramble, output int cycles);
    md_start = 1'b1; md_op = op; a = va; b = vb;
    tick();
    md_start = 1'b0;
    cycles = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      cycles++;
      if (scramble) begin a = $urandom; b = $urandom; end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL reset: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    end
    n_checks++;
    if (busy16 !== 1'b0 || hi16 !== 16'h0 || lo16 !== 16'h0) begin
      n_fail++; $display("FAIL reset16: busy=%b hi=%h lo=%h required 0/0/0", busy16, hi16, lo16);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_alu();
    logic [3:0]  ops [8] = '{ALU_SRA, ALU_SLT, ALU_SLTU, ALU_ADD, ALU_SUB, ALU_NOR, ALU_SRL, 4'd12};
    logic [31:0] va  [8] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                             32'h0000_0000, 32'h0F0F_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] vb  [8] = '{32'h0000_0024, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002,
                             32'h0000_0001, 32'h0000_00F0, 32'h0000_0024, 32'hFFFF_FFFF};
    logic [31:0] exp [8] = '{32'hF800_0000, 32'h0000_0001, 32'h0000_0000, 32'h0000_0001,
                             32'hFFFF_FFFF, 32'hF0F0_FF0F, 32'h0800_0000, 32'h0000_0000};
    for (int i = 0; i < 8; i++) begin
      alu_op = ops[i]; a = va[i]; b = vb[i];
      #1;
      n_checks++;
      if (c !== exp[i]) begin
        n_fail++; $display("FAIL alu[%0d] op=%0d: C=%h required %h", i, ops[i], c, exp[i]);
      end
    end
  endtask

  task automatic test_mult();
    int cyc;
    run_md(MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, cyc);
    n_checks++;
    if (cyc != 5) begin n_fail++; $display("FAIL mult_busy: cycles=%0d required 5", cyc); end
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
      n_fail++; $display("FAIL mult_result: hi=%h lo=%h required ffffffff/fffffffa", hi, lo);
    end
  endtask

  task automatic test_div();
    int cyc;
    run_md(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 1'b1, cyc);
    n_checks++;
    if (cyc != 10) begin n_fail++; $display("FAIL div_busy: cycles=%0d required 10", cyc); end
    n_checks++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFD) begin
      n_fail++; $display("FAIL div_result: hi=%h lo=%h required ffffffff/fffffffd", hi, lo);
    end
    run_md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, cyc);
    n_checks++;
    if (hi !== 32'h0 || lo !== 32'h8000_0000) begin
      n_fail++; $display("FAIL div_min_neg1: hi=%h lo=%h required 00000000/80000000", hi, lo);
    end
    run_md(MD_DIVU, 32'd100, 32'd7, 1'b0, cyc);
    n_checks++;
    if (hi !== 32'd2 || lo !== 32'd14) begin
      n_fail++; $display("FAIL divu_result: hi=%h lo=%h required 00000002/0000000e", hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo_divzero();
    int cyc;
    int rose;
    md_start = 1'b1; md_op = MD_MTHI; a = 32'h0000_1234;
    tick();
    md_op = MD_MTLO; a = 32'h0000_5678;
    tick();
    md_start = 1'b0;
    n_checks++;
    if (hi !== 32'h1234 || lo !== 32'h5678 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mthi_mtlo: hi=%h lo=%h busy=%b required 1234/5678/0", hi, lo, busy);
    end
    run_md(MD_DIVU, 32'h0000_0055, 32'h0, 1'b0, cyc);
    n_checks++;
    if (cyc != 10) begin n_fail++; $display("FAIL divzero_busy: cycles=%0d required 10", cyc); end
    n_checks++;
    if (hi !== 32'h1234 || lo !== 32'h5678) begin
      n_fail++; $display("FAIL divzero_keep: hi=%h lo=%h required 00001234/00005678", hi, lo);
    end
    md_start = 1'b1; md_op = 3'd6; a = 32'hAAAA_AAAA;
    tick();
    md_start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h1234 || lo !== 32'h5678) begin
      n_fail++; $display("FAIL op6_noop: busy=%b hi=%h lo=%h required 0/1234/5678", busy, hi, lo);
    end
    md_start = 1'b1; md_op = MD_MTHI; a = 32'hDEAD_BEEF;
    tick();
    md_start = 1'b0;
    rose = 0;
    n_checks++;
    if (hi !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL mthi: hi=%h required deadbeef", hi);
    end
    for (int i = 0; i < 3; i++) begin
      if (busy) rose = 1;
      tick();
    end
    n_checks++;
    if (rose != 0) begin n_fail++; $display("FAIL mthi_busy: busy rose=%0d required 0", rose); end
  endtask

  task automatic test_busy_ignore();
    int cyc;
    md_start = 1'b1; md_op = MD_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    tick();
    md_op = MD_MTLO; a = 32'h0000_0001;
    tick();
    md_start = 1'b0;
    cyc = 1;
    for (int i = 0; i < 40 && busy; i++) begin
      cyc++;
      tick();
    end
    n_checks++;
    if (cyc != 5) begin n_fail++; $display("FAIL multu_busy: cycles=%0d required 5", cyc); end
    n_checks++;
    if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
      n_fail++; $display("FAIL multu_ignore: hi=%h lo=%h required fffffffe/00000001", hi, lo);
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    int saw42;
    md_start = 1'b1; md_op = MD_MULT; a = 32'd6; b = 32'd7;
    tick();
    md_start = 1'b0;
    tick(); tick();
    // Reset asserted in RUN cycle 3, with a competing mthi to confirm reset wins.
    reset = 1'b0; md_start = 1'b1; md_op = MD_MTHI; a = 32'h0000_0055;
    tick();
    reset = 1'b1; md_start = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      n_fail++; $display("FAIL reset_midrun: busy=%b hi=%h lo=%h required 0/0/0", busy, hi, lo);
    end
    saw42 = 0;
    for (int i = 0; i < 8; i++) begin
      if (lo == 32'd42 || busy) saw42 = 1;
      tick();
    end
    n_checks++;
    if (saw42 != 0) begin n_fail++; $display("FAIL reset_discard: stale activity=%0d required 0", saw42); end
    run_md(MD_MULT, 32'd6, 32'd7, 1'b0, cyc);
    n_checks++;
    if (cyc != 5 || hi !== 32'h0 || lo !== 32'd42) begin
      n_fail++; $display("FAIL restart: cycles=%0d hi=%h lo=%h required 5/0/2a", cyc, hi, lo);
    end
  endtask

  task automatic test_width16();
    int cyc;
    alu_op16 = ALU_SLL; a16 = 16'h0003; b16 = 16'h0011;
    #1;
    n_checks++;
    if (c16 !== 16'h0006) begin n_fail++; $display("FAIL sll16: C=%h required 0006", c16); end
    md_start16 = 1'b1; md_op16 = MD_MULT; a16 = 16'h7FFF; b16 = 16'h7FFF;
    tick();
    md_start16 = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40 && busy16; i++) begin
      cyc++;
      tick();
    end
    n_checks++;
    if (cyc != 1) begin n_fail++; $display("FAIL mult16_busy: cycles=%0d required 1", cyc); end
    n_checks++;
    if (hi16 !== 16'h3FFF || lo16 !== 16'h0001) begin
      n_fail++; $display("FAIL mult16_result: hi=%h lo=%h required 3fff/0001", hi16, lo16);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mult();
    test_div();
    test_mthi_mtlo_divzero();
    test_busy_ignore();
    test_reset_midrun();
    test_width16();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
